ccgc_stream_seq: RTL and testbench
==================================

Name: ccgc_stream_seq

Overview:
- Sequencer that replays one stored complementary-Gray-code (CCGC) frame set into the ccgc decoder as a raster stream.
- Reads a 5-plane bit frame store in raster order and drives frame_valid, line_valid and the five per-pixel gray bits, with programmable blanking.
- Counts the decoder's K_valid beats to confirm completion, then returns a done pulse.
- Sits between the capture frame store and the decoder; software sees only the start/busy/done/error handshake.

Parameters:
- ADDR_W, 24, frame-store address width; must satisfy 2^ADDR_W >= max width*height.
- DIM_W, 12, width of img_width/img_height.
- FV_PRE, 4, cycles frame_valid is high before the first line (min 1).
- H_BLANK, 8, idle cycles between lines, line_valid low (min 1).
- TIMEOUT, 1024, drain watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE
- img_width  in  DIM_W  pixels per line; latched on accepted start
- img_height  in  DIM_W  lines per frame; latched on accepted start
- rd_en  out  1  frame-store read strobe
- rd_addr  out  ADDR_W  raster address, line*width+col
- rd_data  in  5  {ccp1_n_1, ccp4_n, ccp3_n, ccp2_n, ccp1_n}; valid 1 cycle after rd_en
- frame_valid  out  1  to decoder
- line_valid  out  1  to decoder
- gray_ccp1_n, gray_ccp2_n, gray_ccp3_n, gray_ccp4_n, gray_ccp1_n_1  out  1 each  to decoder
- K_valid  in  1  decoder output-valid beat
- busy  out  1  high from accepted start to done
- done  out  1  one-cycle pulse at completion
- even_frame  out  1  mirrors the decoder parity; toggles on each frame_valid rising edge
- err  out  1  sticky: bad dimensions or timeout; cleared on the next accepted start

Behaviour:
- Reset value of every output is 0, including err and even_frame. FSM resets to IDLE.
- IDLE:
  - start=1 with both dimensions nonzero: latch dimensions, clear err, clear the pixel counter, go to SOF. frame_valid and busy are high from the next cycle.
  - start=1 with either dimension zero: set err, pulse done, stay in IDLE.
- SOF: frame_valid high for FV_PRE cycles, then go to LINE.
- LINE:
  - rd_en=1 for exactly img_width cycles; rd_addr increments by 1 from 0 across the whole frame with no per-line reset.
  - line_valid is rd_en delayed by 1 cycle. Each gray_* output equals the matching rd_data bit when line_valid=1, else 0.
  - After the last column: go to HBLANK, or to DRAIN if this was the last line.
- HBLANK: H_BLANK cycles, then back to LINE.
- DRAIN:
  - frame_valid drops 1 cycle after the last line_valid beat.
  - Wait until the K_valid beat count reaches width*height, then go to DONE.
  - K_valid beats arriving in any state other than IDLE are counted.
- DONE: done=1 for 1 cycle, busy drops, go to IDLE.
- K_valid beats beyond width*height (extra beats) set err; they do not stall the FSM.
- even_frame toggles on the cycle frame_valid rises.
- abort in any state:
  - Next cycle: FSM in IDLE; frame_valid, line_valid, rd_en, busy and the gray outputs all 0.
  - No done pulse. even_frame is kept.
  - Pending K_valid beats are ignored after the abort.
- start while busy is ignored. A start in the same cycle as DONE is ignored; the sequencer accepts start from the following IDLE cycle.
- abort and start in the same cycle: abort wins.
- Width 1 and height 1 are legal: one beat, one line.
- The pixel counter is ADDR_W+1 bits and does not wrap for any legal width*height.

Optional Feature:
- Macro CCGC_SEQ_TIMEOUT_EN.
- Defined: a DRAIN cycle counter runs. When it reaches TIMEOUT before the beat count completes, set err and go to DONE, which still pulses done.
- Undefined: DRAIN waits indefinitely; only abort exits it.

Decomposition:
- Package ccgc_pkg holds:
  - the FSM state enum (IDLE, SOF, LINE, HBLANK, DRAIN, DONE);
  - rd_data bit-index constants;
  - the decoder pipeline latency constant CCGC_DEC_LAT = 6.
- One natural sub-module, ccgc_raster_cnt: column/line/address counters with last_col/last_line flags.

Test Plan:
- Width 4, height 2, loopback decoder model with latency 6: 8 rd_en beats, addresses 0..7, line_valid high 4 cycles twice separated by 8 low; done pulses after the 8th K_valid; err=0.
- rd_data=5'b10101 constant: the gray outputs equal {1,0,1,0,1} only while line_valid=1, and are 0 elsewhere.
- Two back-to-back runs: even_frame is 1 after the first, 0 after the second.
- start with img_width=0: err=1, done pulse next cycle, no rd_en ever.
- abort mid-LINE (width 16, at column 5): next cycle all strobes are 0, busy=0, no done; a new start then restarts at address 0.
- With CCGC_SEQ_TIMEOUT_EN, TIMEOUT=20, decoder model emits only 7 of 8 beats: err=1, done exactly 20 cycles after DRAIN entry.

Source files
------------

// File: rtl/ccgc_pkg.sv
// ccgc_pkg: shared FSM states, frame-store bit layout and decoder latency for the CCGC stream sequencer
package ccgc_pkg;
  typedef enum logic [2:0] {IDLE, SOF, LINE, HBLANK, DRAIN, DONE} ccgc_state_e;
  localparam int unsigned RD_CCP1_N = 0;
  localparam int unsigned RD_CCP2_N = 1;
  localparam int unsigned RD_CCP3_N = 2;
  localparam int unsigned RD_CCP4_N = 3;
  localparam int unsigned RD_CCP1_N_1 = 4;
  localparam int unsigned CCGC_DEC_LAT = 6;
endpackage

// File: rtl/ccgc_raster_cnt.sv
// ccgc_raster_cnt: column/line/address raster counters with last-column and last-line flags
module ccgc_raster_cnt
  import ccgc_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DIM_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_line
);
  logic [DIM_W-1:0] col_q, col_d, line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  assign last_col = col_q == width - 1'b1;
  assign last_line = line_q == height - 1'b1;
  assign addr = addr_q;
  // address runs continuously across lines: line*width+col without a multiplier
  always_comb begin
    col_d = clr ? '0 : en ? (last_col ? '0 : col_q + 1'b1) : col_q;
    line_d = clr ? '0 : (en && last_col) ? line_q + 1'b1 : line_q;
    addr_d = clr ? '0 : en ? addr_q + 1'b1 : addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      col_q <= col_d;
      line_q <= line_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/ccgc_stream_seq.sv
// ccgc_stream_seq: replays a stored 5-plane CCGC frame into the decoder as a raster stream and waits for its beats.
// Define CCGC_SEQ_TIMEOUT_EN to bound the DRAIN wait by TIMEOUT cycles.
module ccgc_stream_seq
  import ccgc_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DIM_W = 12,
  parameter int FV_PRE = 4,
  parameter int H_BLANK = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [4:0]        rd_data,
  output logic              frame_valid,
  output logic              line_valid,
  output logic              gray_ccp1_n,
  output logic              gray_ccp2_n,
  output logic              gray_ccp3_n,
  output logic              gray_ccp4_n,
  output logic              gray_ccp1_n_1,
  input  logic              K_valid,
  output logic              busy,
  output logic              done,
  output logic              even_frame,
  output logic              err
);
  localparam int PH_W = $clog2(TIMEOUT + FV_PRE + H_BLANK + 1) + 1;
  ccgc_state_e state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [ADDR_W:0] total_q, total_d, kcnt_q, kcnt_d;
  logic err_q, err_d, ef_q, ef_d, done_q, done_d, lv_q, lv_d;
  logic last_col, last_line, req, accept, bad, k_beat, k_full, tmo;
  assign req = state_q == IDLE && start && !abort;
  assign accept = req && |img_width && |img_height;
  assign bad = req && !(|img_width && |img_height);
  assign k_beat = K_valid && state_q != IDLE && !abort;
  assign k_full = kcnt_q >= total_q;
`ifdef CCGC_SEQ_TIMEOUT_EN
  assign tmo = state_q == DRAIN && !k_full && ph_q == PH_W'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  ccgc_raster_cnt #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(accept), .en(rd_en), .width(w_q), .height(h_q),
    .addr(rd_addr), .last_col(last_col), .last_line(last_line)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? SOF : IDLE;
      SOF: state_d = ph_q == PH_W'(FV_PRE - 1) ? LINE : SOF;
      LINE: state_d = last_col ? (last_line ? DRAIN : HBLANK) : LINE;
      HBLANK: state_d = ph_q == PH_W'(H_BLANK - 1) ? LINE : HBLANK;
      DRAIN: state_d = (k_full || tmo) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    ph_d = state_d == state_q ? ph_q + 1'b1 : '0;
    w_d = accept ? img_width : w_q;
    h_d = accept ? img_height : h_q;
    total_d = accept ? (ADDR_W+1)'(img_width) * (ADDR_W+1)'(img_height) : total_q;
    kcnt_d = accept ? '0 : kcnt_q + (ADDR_W+1)'(k_beat);
    err_d = accept ? 1'b0 : err_q | bad | (k_beat && k_full) | (tmo && !abort);
    ef_d = ef_q ^ accept;
    done_d = bad || state_d == DONE;
    lv_d = rd_en && !abort;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q <= '0;
      w_q <= '0;
      h_q <= '0;
      total_q <= '0;
      kcnt_q <= '0;
      err_q <= 1'b0;
      ef_q <= 1'b0;
      done_q <= 1'b0;
      lv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      w_q <= w_d;
      h_q <= h_d;
      total_q <= total_d;
      kcnt_q <= kcnt_d;
      err_q <= err_d;
      ef_q <= ef_d;
      done_q <= done_d;
      lv_q <= lv_d;
    end
  end
  // frame_valid stays up through the DRAIN cycle carrying the final line beat
  assign rd_en = state_q == LINE;
  assign line_valid = lv_q;
  assign frame_valid = state_q == SOF || state_q == LINE || state_q == HBLANK || lv_q;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = done_q;
  assign err = err_q;
  assign even_frame = ef_q;
  assign gray_ccp1_n = lv_q & rd_data[RD_CCP1_N];
  assign gray_ccp2_n = lv_q & rd_data[RD_CCP2_N];
  assign gray_ccp3_n = lv_q & rd_data[RD_CCP3_N];
  assign gray_ccp4_n = lv_q & rd_data[RD_CCP4_N];
  assign gray_ccp1_n_1 = lv_q & rd_data[RD_CCP1_N_1];
endmodule

// File: tb/tb_ccgc_stream_seq.sv
// tb_ccgc_stream_seq: directed bench with frame-store and latency-6 loopback decoder models and a gray-data scoreboard
module tb_ccgc_stream_seq;
  import ccgc_pkg::*;
`ifdef CCGC_SEQ_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 1024;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [11:0] img_width = '0, img_height = '0;
  logic rd_en, frame_valid, line_valid, busy, done, even_frame, err;
  logic [23:0] rd_addr;
  logic [4:0] rd_data = '0;
  logic gray_ccp1_n, gray_ccp2_n, gray_ccp3_n, gray_ccp4_n, gray_ccp1_n_1, K_valid;
  logic [CCGC_DEC_LAT-1:0] kpipe = '0;
  logic const_mode = 1'b0;
  int tests = 0, fails = 0, cyc = 0;
  int k_emit = 0, kv_limit = 1 << 30;
  int rd_cnt = 0, k_seen = 0, done_cnt = 0, done_cyc = 0, k_at_done = 0;
  int last_k_cyc = 0, last_rd_cyc = 0, lv_last_cyc = 0, fv_fall_cyc = 0, run_len = 0;
  logic [23:0] exp_addr = '0;
  logic [4:0] exp_q[$];
  int runs[$];
  logic lv_prev = 1'b0, fv_prev = 1'b0;

  ccgc_stream_seq #(.ADDR_W(24), .DIM_W(12), .FV_PRE(4), .H_BLANK(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .img_width(img_width), .img_height(img_height),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid), .line_valid(line_valid),
    .gray_ccp1_n(gray_ccp1_n), .gray_ccp2_n(gray_ccp2_n), .gray_ccp3_n(gray_ccp3_n),
    .gray_ccp4_n(gray_ccp4_n), .gray_ccp1_n_1(gray_ccp1_n_1), .K_valid(K_valid),
    .busy(busy), .done(done), .even_frame(even_frame), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] pat(input logic [23:0] a);
    return a[4:0] ^ 5'h0b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // frame store: one-cycle read latency; drives junk between reads to expose ungated gray outputs
  always @(posedge clk) rd_data <= const_mode ? 5'b10101 : rd_en ? pat(rd_addr) : 5'b11111;

  // loopback decoder: one K_valid per line_valid beat, CCGC_DEC_LAT cycles later, optionally truncated
  always @(posedge clk) begin
    cyc <= cyc + 1;
    kpipe <= {kpipe[CCGC_DEC_LAT-2:0], line_valid};
    if (K_valid) k_emit <= k_emit + 1;
  end
  assign K_valid = kpipe[CCGC_DEC_LAT-1] && (k_emit < kv_limit);

  always @(negedge clk) if (!rst) begin
    logic [4:0] g;
    g = {gray_ccp1_n_1, gray_ccp4_n, gray_ccp3_n, gray_ccp2_n, gray_ccp1_n};
    if (!busy) begin
      exp_addr = '0;
      exp_q.delete();
    end
    if (rd_en) begin
      chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
      exp_q.push_back(const_mode ? 5'b10101 : pat(exp_addr));
      exp_addr++;
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (line_valid) begin
      chk("gray_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("gray", 32'(g), 32'(exp_q.pop_front()));
      lv_last_cyc = cyc;
    end else chk("gray_idle", 32'(g), 32'd0);
    if (K_valid) begin
      k_seen++;
      last_k_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      k_at_done = k_seen;
    end
    if (fv_prev && !frame_valid) fv_fall_cyc = cyc;
    fv_prev = frame_valid;
    if (line_valid != lv_prev) begin
      runs.push_back(run_len);
      run_len = 1;
    end else run_len++;
    lv_prev = line_valid;
  end

  task automatic run_start(input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1;
    img_width = 12'(w);
    img_height = 12'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_arrived", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int base, rd0, k0, d0, n;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_strobes", {frame_valid, line_valid, rd_en, busy, done}, 0);
    chk("rst_flags", {err, even_frame}, 0);
    chk("rst_gray", {gray_ccp1_n_1, gray_ccp4_n, gray_ccp3_n, gray_ccp2_n, gray_ccp1_n}, 0);
    rst = 1'b0;

    // 4x2 frame, with an ignored start request while busy
    base = runs.size(); rd0 = rd_cnt; k0 = k_seen; d0 = done_cnt;
    run_start(4, 2);
    chk("start_fv_busy", {frame_valid, busy}, 2'b11);
    chk("start_even", even_frame, 1);
    start = 1'b1; img_width = '0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300);
    chk("t1_reads", rd_cnt - rd0, 8);
    chk("t1_line0", runs[base+1], 4);
    chk("t1_hblank", runs[base+2], 8);
    chk("t1_line1", runs[base+3], 4);
    chk("t1_fv_drop", fv_fall_cyc - lv_last_cyc, 1);
    chk("t1_k_at_done", k_at_done - k0, 8);
    chk("t1_done_lat_ok", (done_cyc - last_k_cyc) <= 3, 1);
    chk("t1_err", err, 0);
    chk("t1_busy_after", {busy, done}, 0);
    repeat (5) @(posedge clk);
    chk("t1_single_done", done_cnt - d0, 1);
    chk("t1_even", even_frame, 1);

    // constant frame data: gray bits visible only under line_valid
    const_mode = 1'b1; rd0 = rd_cnt;
    run_start(3, 2);
    wait_done(300);
    chk("t2_reads", rd_cnt - rd0, 6);
    chk("t2_even", even_frame, 0);
    const_mode = 1'b0;

    // zero width rejected
    rd0 = rd_cnt; d0 = done_cnt;
    run_start(0, 3);
    chk("t3_done_err", {done, err, busy}, 3'b110);
    @(posedge clk); #1;
    chk("t3_done_pulse", {done, err, busy}, 3'b010);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_no_reads", rd_cnt - rd0, 0);
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk("t3_even_kept", even_frame, 0);

    // abort at column 5 of a 16-wide line
    d0 = done_cnt;
    run_start(16, 2);
    chk("t4_err_cleared", err, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_en && rd_addr == 24'd5) && n < 100);
    chk("t4_reached_col5", n < 100, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t4_strobes", {frame_valid, line_valid, rd_en, busy, done}, 0);
    chk("t4_gray", {gray_ccp1_n_1, gray_ccp4_n, gray_ccp3_n, gray_ccp2_n, gray_ccp1_n}, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_err", err, 0);
    chk("t4_even_kept", even_frame, 1);
    rd0 = rd_cnt; k0 = k_seen;
    run_start(2, 1);
    wait_done(300);
    chk("t4_restart_reads", rd_cnt - rd0, 2);
    chk("t4_restart_k", k_at_done - k0, 2);
    chk("t4_restart_err", err, 0);

    // minimal 1x1 frame
    rd0 = rd_cnt; k0 = k_seen; base = runs.size();
    run_start(1, 1);
    wait_done(300);
    chk("t5_reads", rd_cnt - rd0, 1);
    chk("t5_lv_len", runs[base+1], 1);
    chk("t5_k", k_at_done - k0, 1);
    chk("t5_err", err, 0);

`ifdef CCGC_SEQ_TIMEOUT_EN
    // decoder delivers only 7 of 8 beats: watchdog ends DRAIN after TIMEOUT cycles
    repeat (10) @(posedge clk);
    kv_limit = k_emit + 7;
    run_start(4, 2);
    wait_done(400);
    chk("t6_err", err, 1);
    chk("t6_done_after_drain", done_cyc - (last_rd_cyc + 1), 20);
    kv_limit = 1 << 30;
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
